// File: rtl/dp_ram_pkg.sv
// Shared types and defaults for the dual-port RAM access controller.
// Optional build macro: DP_RAM_COLL_CNT_EN (collision stall counter).
package dp_ram_pkg;

  localparam int AW = 6;
  localparam int DW = 64;
  localparam int STARVE_LIMIT = 4;
  localparam logic [DW-1:0] INIT_VALUE = '0;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dp_req_t;

  // Two writes to the same word in one cycle
  function automatic logic is_coll(
    input logic    va,
    input logic    vb,
    input dp_req_t a,
    input dp_req_t b
  );
    return va & vb & a.we & b.we & (a.addr == b.addr);
  endfunction

endpackage

// File: rtl/dp_ram_access_ctrl_if.sv
// Request/response channels A and B of the RAM access controller.
// Optional build macro: DP_RAM_COLL_CNT_EN (no effect on this interface).
interface dp_ram_access_ctrl_if;
  import dp_ram_pkg::*;

  logic          req_a_valid;
  logic          req_a_ready;
  logic          req_a_we;
  logic [AW-1:0] req_a_addr;
  logic [DW-1:0] req_a_wdata;
  logic          rsp_a_valid;
  logic [DW-1:0] rsp_a_rdata;

  logic          req_b_valid;
  logic          req_b_ready;
  logic          req_b_we;
  logic [AW-1:0] req_b_addr;
  logic [DW-1:0] req_b_wdata;
  logic          rsp_b_valid;
  logic [DW-1:0] rsp_b_rdata;

  modport master (
    output req_a_valid, req_a_we,
    output req_a_addr, req_a_wdata,
    input  req_a_ready,
    input  rsp_a_valid, rsp_a_rdata,
    output req_b_valid, req_b_we,
    output req_b_addr, req_b_wdata,
    input  req_b_ready,
    input  rsp_b_valid, rsp_b_rdata
  );

  modport slave (
    input  req_a_valid, req_a_we,
    input  req_a_addr, req_a_wdata,
    output req_a_ready,
    output rsp_a_valid, rsp_a_rdata,
    input  req_b_valid, req_b_we,
    input  req_b_addr, req_b_wdata,
    output req_b_ready,
    output rsp_b_valid, rsp_b_rdata
  );

endinterface

// File: rtl/dp_ram_init_seq.sv
// Post-reset zero-fill sweep: two words per cycle, 32 cycles.
// Optional build macro: DP_RAM_COLL_CNT_EN (no effect on this module).
module dp_ram_init_seq
  import dp_ram_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          drive,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          last,
  output logic          done
);

  logic [AW-2:0] k;

  // Port A takes the even word, port B the odd one.
  // Gated by rst_n so the RAM sees no writes while reset is held.
  assign drive  = en & rst_n;
  assign addr_a = {k, 1'b0};
  assign addr_b = {k, 1'b1};
  assign last   = en & (k == '1);

  // Sweep counter and sticky completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= '0;
      done <= 1'b0;
    end else if (en) begin
      k <= k + 1'b1;
      if (last) done <= 1'b1;
    end
  end

endmodule

// File: rtl/dp_ram_access_ctrl.sv
// Two-channel initiator for a 64x64 dual-port RAM with async read.
// Optional build macro: DP_RAM_COLL_CNT_EN adds the coll_cnt output.
module dp_ram_access_ctrl #(
  parameter int AW = dp_ram_pkg::AW,
  parameter int DW = dp_ram_pkg::DW,
  parameter logic [DW-1:0] INIT_VALUE = dp_ram_pkg::INIT_VALUE,
  parameter int STARVE_LIMIT = dp_ram_pkg::STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst_n,
  dp_ram_access_ctrl_if.slave bus,
  output logic          init_done,
  output logic [1:0]    ram_rw,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_din_a,
  output logic [DW-1:0] ram_din_b,
  input  logic [DW-1:0] ram_dout_a,
  input  logic [DW-1:0] ram_dout_b
`ifdef DP_RAM_COLL_CNT_EN
  ,
  output logic [15:0]   coll_cnt
`endif
);
  import dp_ram_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t        state;
  dp_req_t       ra;
  dp_req_t       rb;
  logic          run;
  logic          coll;
  logic          starve_hit;
  logic          rdy_a;
  logic          rdy_b;
  logic          acc_a;
  logic          acc_b;
  logic [SW-1:0] starve_cnt;

  logic          init_drive;
  logic          init_last;
  logic [AW-1:0] init_addr_a;
  logic [AW-1:0] init_addr_b;

  logic          rsp_a_v;
  logic          rsp_b_v;
  logic [DW-1:0] rsp_a_d;
  logic [DW-1:0] rsp_b_d;

  dp_ram_init_seq u_init (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == INIT),
    .drive  (init_drive),
    .addr_a (init_addr_a),
    .addr_b (init_addr_b),
    .last   (init_last),
    .done   (init_done)
  );

  assign ra = '{
    we:    bus.req_a_we,
    addr:  bus.req_a_addr,
    wdata: bus.req_a_wdata
  };
  assign rb = '{
    we:    bus.req_b_we,
    addr:  bus.req_b_addr,
    wdata: bus.req_b_wdata
  };

  // Collisions favour A until B has been starved STARVE_LIMIT times.
  assign run  = (state == RUN);
  assign coll = run & is_coll(bus.req_a_valid, bus.req_b_valid, ra, rb);
  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
  assign rdy_a = run & ~(coll & starve_hit);
  assign rdy_b = run & ~(coll & ~starve_hit);
  assign acc_a = bus.req_a_valid & rdy_a;
  assign acc_b = bus.req_b_valid & rdy_b;

  assign bus.req_a_ready = rdy_a;
  assign bus.req_b_ready = rdy_b;
  assign bus.rsp_a_valid = rsp_a_v;
  assign bus.rsp_b_valid = rsp_b_v;
  assign bus.rsp_a_rdata = rsp_a_d;
  assign bus.rsp_b_rdata = rsp_b_d;

  // RAM port drive: sweep in INIT, pass-through of requests in RUN
  always_comb begin
    ram_rw     = 2'b00;
    ram_addr_a = ra.addr;
    ram_addr_b = rb.addr;
    ram_din_a  = ra.wdata;
    ram_din_b  = rb.wdata;
    unique case (1'b1)
      init_drive: begin
        ram_rw     = 2'b11;
        ram_addr_a = init_addr_a;
        ram_addr_b = init_addr_b;
        ram_din_a  = INIT_VALUE;
        ram_din_b  = INIT_VALUE;
      end
      run: begin
        ram_rw = {acc_b & rb.we, acc_a & ra.we};
      end
      default: begin
      end
    endcase
  end

  // Controller FSM: sweep once after reset, then serve requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      case (state)
        INIT:    if (init_last) state <= RUN;
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Count consecutive B stalls; any B acceptance clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!run || acc_b) begin
      starve_cnt <= '0;
    end else if (coll && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Read responses: capture async RAM data at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_a_v <= 1'b0;
      rsp_b_v <= 1'b0;
      rsp_a_d <= '0;
      rsp_b_d <= '0;
    end else begin
      rsp_a_v <= acc_a & ~ra.we;
      rsp_b_v <= acc_b & ~rb.we;
      if (acc_a && !ra.we) rsp_a_d <= ram_dout_a;
      if (acc_b && !rb.we) rsp_b_d <= ram_dout_b;
    end
  end

`ifdef DP_RAM_COLL_CNT_EN
  // Saturating count of collision stall cycles on either port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt <= '0;
    end else if (coll && coll_cnt != 16'hFFFF) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dp_ram_access_ctrl.sv
// Directed bench for dp_ram_access_ctrl with a behavioural 64x64 RAM.
// Optional build macro: DP_RAM_COLL_CNT_EN enables coll_cnt checks.
module tb_dp_ram_access_ctrl;
  import dp_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [1:0]  ram_rw;
  logic [5:0]  ram_addr_a;
  logic [5:0]  ram_addr_b;
  logic [63:0] ram_din_a;
  logic [63:0] ram_din_b;
  logic [63:0] ram_dout_a;
  logic [63:0] ram_dout_b;
`ifdef DP_RAM_COLL_CNT_EN
  logic [15:0] coll_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dp_ram_access_ctrl_if bus();

  dp_ram_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .init_done  (init_done),
    .ram_rw     (ram_rw),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_din_a  (ram_din_a),
    .ram_din_b  (ram_din_b),
    .ram_dout_a (ram_dout_a),
    .ram_dout_b (ram_dout_b)
`ifdef DP_RAM_COLL_CNT_EN
    ,
    .coll_cnt   (coll_cnt)
`endif
  );

  logic [63:0] mem [64];

  always @(posedge clk) begin
    if (ram_rw[0]) mem[ram_addr_a] <= ram_din_a;
    if (ram_rw[1]) mem[ram_addr_b] <= ram_din_b;
  end

  assign ram_dout_a = mem[ram_addr_a];
  assign ram_dout_b = mem[ram_addr_b];

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_a_valid = 1'b0;
    bus.req_a_we    = 1'b0;
    bus.req_a_addr  = '0;
    bus.req_a_wdata = '0;
    bus.req_b_valid = 1'b0;
    bus.req_b_we    = 1'b0;
    bus.req_b_addr  = '0;
    bus.req_b_wdata = '0;
  endtask

  task automatic set_a(input logic we, input logic [5:0] a,
                       input logic [63:0] d);
    bus.req_a_valid = 1'b1;
    bus.req_a_we    = we;
    bus.req_a_addr  = a;
    bus.req_a_wdata = d;
  endtask

  task automatic set_b(input logic we, input logic [5:0] a,
                       input logic [63:0] d);
    bus.req_b_valid = 1'b1;
    bus.req_b_we    = we;
    bus.req_b_addr  = a;
    bus.req_b_wdata = d;
  endtask

  // Entered just after rst_n release; walks the 32 sweep cycles
  task automatic run_init(input string tag);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk({tag, "_rdy_a"}, bus.req_a_ready, 0);
      chk({tag, "_rdy_b"}, bus.req_b_ready, 0);
      if (i == 0) begin
        chk({tag, "_rw0"}, ram_rw, 2'b11);
        chk({tag, "_addr_a0"}, ram_addr_a, 0);
        chk({tag, "_addr_b0"}, ram_addr_b, 1);
      end
      if (i == 31) begin
        chk({tag, "_addr_a31"}, ram_addr_a, 62);
        chk({tag, "_addr_b31"}, ram_addr_b, 63);
        chk({tag, "_done31"}, init_done, 0);
      end
      cyc();
    end
    #1;
    chk({tag, "_done"}, init_done, 1);
    chk({tag, "_run_rdy_a"}, bus.req_a_ready, 1);
    chk({tag, "_run_rdy_b"}, bus.req_b_ready, 1);
  endtask

  task automatic read_a(input logic [5:0] a, input logic [63:0] exp,
                        input string tag);
    set_a(1'b0, a, '0);
    #1;
    chk({tag, "_rdy"}, bus.req_a_ready, 1);
    cyc();
    bus.req_a_valid = 1'b0;
    chk({tag, "_vld"}, bus.rsp_a_valid, 1);
    chk({tag, "_data"}, bus.rsp_a_rdata, exp);
    cyc();
    chk({tag, "_pulse"}, bus.rsp_a_valid, 0);
  endtask

  task automatic read_b(input logic [5:0] a, input logic [63:0] exp,
                        input string tag);
    set_b(1'b0, a, '0);
    #1;
    chk({tag, "_rdy"}, bus.req_b_ready, 1);
    cyc();
    bus.req_b_valid = 1'b0;
    chk({tag, "_vld"}, bus.rsp_b_valid, 1);
    chk({tag, "_data"}, bus.rsp_b_rdata, exp);
    cyc();
    chk({tag, "_pulse"}, bus.rsp_b_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy_a", bus.req_a_ready, 0);
    chk("rst_rdy_b", bus.req_b_ready, 0);
    chk("rst_done", init_done, 0);
    chk("rst_rsp_a", bus.rsp_a_valid, 0);
    chk("rst_rsp_b", bus.rsp_b_valid, 0);
    chk("rst_rdata_a", bus.rsp_a_rdata, 0);
    chk("rst_rw", ram_rw, 0);

    rst_n = 1'b1;
    run_init("init");

    // Post-init readback, A and B in the same cycle
    set_a(1'b0, 6'd0, '0);
    set_b(1'b0, 6'd31, '0);
    cyc();
    idle();
    chk("init_rd0_vld", bus.rsp_a_valid, 1);
    chk("init_rd0_data", bus.rsp_a_rdata, 0);
    chk("init_rd31_vld", bus.rsp_b_valid, 1);
    chk("init_rd31_data", bus.rsp_b_rdata, 0);
    cyc();
    chk("init_rd_pulse", bus.rsp_a_valid, 0);
    read_a(6'd63, 64'h0, "init_rd63");

    // A writes @5, B reads it back
    set_a(1'b1, 6'd5, 64'h1234_5678_9ABC_DEF0);
    #1;
    chk("wr5_rw", ram_rw, 2'b01);
    chk("wr5_rsp", bus.rsp_a_valid, 0);
    cyc();
    idle();
    read_b(6'd5, 64'h1234_5678_9ABC_DEF0, "rd5");

    // Same-address write collision @9
    set_a(1'b1, 6'd9, 64'hAAAA_AAAA_AAAA_AAAA);
    set_b(1'b1, 6'd9, 64'hBBBB_BBBB_BBBB_BBBB);
    #1;
    chk("coll_rdy_a", bus.req_a_ready, 1);
    chk("coll_rdy_b", bus.req_b_ready, 0);
    chk("coll_rw", ram_rw, 2'b01);
    cyc();
    bus.req_a_valid = 1'b0;
    #1;
    chk("coll_b_rdy", bus.req_b_ready, 1);
    chk("coll_b_rw", ram_rw, 2'b10);
    cyc();
    idle();
    read_a(6'd9, 64'hBBBB_BBBB_BBBB_BBBB, "coll_rd9");

    // Starvation guard @3: four B stalls, then A stalls once
    set_b(1'b1, 6'd3, 64'hB3B3_B3B3_B3B3_B3B3);
    for (int i = 1; i <= 4; i++) begin
      set_a(1'b1, 6'd3, 64'hA0 + 64'(i));
      #1;
      chk("starve_rdy_b", bus.req_b_ready, 0);
      chk("starve_rdy_a", bus.req_a_ready, 1);
      cyc();
    end
    #1;
    chk("starve5_rdy_a", bus.req_a_ready, 0);
    chk("starve5_rdy_b", bus.req_b_ready, 1);
    chk("starve5_rw", ram_rw, 2'b10);
    cyc();
    idle();
    read_b(6'd3, 64'hB3B3_B3B3_B3B3_B3B3, "starve_rd3");
    set_a(1'b1, 6'd3, 64'hA6);
    set_b(1'b1, 6'd3, 64'hB6);
    #1;
    chk("starve_clr_rdy_b", bus.req_b_ready, 0);
    chk("starve_clr_rdy_a", bus.req_a_ready, 1);
    cyc();
    idle();
`ifdef DP_RAM_COLL_CNT_EN
    chk("coll_cnt", coll_cnt, 7);
`endif

    // Read-before-write @7, then read/read @7
    set_a(1'b1, 6'd7, 64'h11);
    cyc();
    idle();
    set_a(1'b0, 6'd7, '0);
    set_b(1'b1, 6'd7, 64'h22);
    #1;
    chk("rbw_rdy_a", bus.req_a_ready, 1);
    chk("rbw_rdy_b", bus.req_b_ready, 1);
    chk("rbw_rw", ram_rw, 2'b10);
    cyc();
    idle();
    chk("rbw_vld", bus.rsp_a_valid, 1);
    chk("rbw_old", bus.rsp_a_rdata, 64'h11);
    chk("rbw_b_novld", bus.rsp_b_valid, 0);
    cyc();
    set_a(1'b0, 6'd7, '0);
    set_b(1'b0, 6'd7, '0);
    cyc();
    idle();
    chk("rr_a", bus.rsp_a_rdata, 64'h22);
    chk("rr_b", bus.rsp_b_rdata, 64'h22);
    chk("rr_vld_b", bus.rsp_b_valid, 1);
    cyc();

    // Reset while a read response is outstanding
    set_a(1'b0, 6'd5, '0);
    cyc();
    idle();
    chk("mid_pre_vld", bus.rsp_a_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_a", bus.rsp_a_valid, 0);
    chk("mid_done", init_done, 0);
    chk("mid_rdy_a", bus.req_a_ready, 0);
    chk("mid_rw", ram_rw, 0);
`ifdef DP_RAM_COLL_CNT_EN
    chk("mid_coll_cnt", coll_cnt, 0);
`endif
    repeat (2) cyc();
    rst_n = 1'b1;
    run_init("reinit");
    read_a(6'd5, 64'h0, "re_rd5");
    read_b(6'd9, 64'h0, "re_rd9");
    read_a(6'd3, 64'h0, "re_rd3");
    read_b(6'd7, 64'h0, "re_rd7");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
